bip_core_v2: RTL and testbench

Parametrised second-generation BIP accumulator CPU core; it drives external synchronous program and data memories.
Extends the base BIP ISA (HLT/STO/LD/LDI/ADD/ADDI/SUB/SUBI) with logic, shift and branch instructions.
Adds a run/step/halt control FSM and debug visibility of the accumulator (ACC) and program counter (PC).
Instantiated inside the BIP top level in place of the original CPU.

---
 rtl/bip_pkg.sv | 42 ++++
 rtl/bip_alu.sv | 36 +++
 rtl/bip_core_v2.sv | 190 +++++++++++++++++++
 tb/tb_bip_core_v2.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// bip_pkg: opcodes, control FSM states and sizing helper
// shared by the bip_core_v2 accumulator CPU.
package bip_pkg;

  localparam int OP_HLT  = 0;
  localparam int OP_STO  = 1;
  localparam int OP_LD   = 2;
  localparam int OP_LDI  = 3;
  localparam int OP_ADD  = 4;
  localparam int OP_ADDI = 5;
  localparam int OP_SUB  = 6;
  localparam int OP_SUBI = 7;
  localparam int OP_AND  = 8;
  localparam int OP_ANDI = 9;
  localparam int OP_OR   = 10;
  localparam int OP_ORI  = 11;
  localparam int OP_XOR  = 12;
  localparam int OP_XORI = 13;
  localparam int OP_SLL  = 14;
  localparam int OP_SRA  = 15;
  localparam int OP_BEQ  = 16;
  localparam int OP_BNE  = 17;
  localparam int OP_JMP  = 18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  // bits needed to hold value (0 -> 0)
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int v = value; v > 0; v = v >> 1)
      r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/bip_alu.sv
// bip_alu: combinational next-ACC computation
// for load, arithmetic, logic and shift opcodes.
module bip_alu
  import bip_pkg::*;
#(
  parameter int NB_DATA   = 16,
  parameter int NB_OPCODE = 5
) (
  input  logic [NB_DATA-1:0]   i_acc,
  input  logic [NB_DATA-1:0]   i_operand,
  input  logic [NB_OPCODE-1:0] i_opcode,
  output logic [NB_DATA-1:0]   o_acc
);

  localparam int NB_SH = clogb2(NB_DATA-1);

  logic [NB_SH-1:0] sh;

  assign sh = i_operand[NB_SH-1:0];

  always_comb begin
    o_acc = i_acc;
    unique case (int'(i_opcode))
      OP_LD, OP_LDI:   o_acc = i_operand;
      OP_ADD, OP_ADDI: o_acc = i_acc + i_operand;
      OP_SUB, OP_SUBI: o_acc = i_acc - i_operand;
      OP_AND, OP_ANDI: o_acc = i_acc & i_operand;
      OP_OR, OP_ORI:   o_acc = i_acc | i_operand;
      OP_XOR, OP_XORI: o_acc = i_acc ^ i_operand;
      OP_SLL:          o_acc = i_acc << sh;
      OP_SRA:          o_acc = $signed(i_acc) >>> sh;
      default:         o_acc = i_acc;
    endcase
  end

endmodule

// File: rtl/bip_core_v2.sv
// bip_core_v2: accumulator CPU with run/step/halt control.
// Define BIP_CYCLE_COUNTER_EN to add the o_cycles counter.
module bip_core_v2
  import bip_pkg::*;
#(
  parameter int NB_DATA        = 16,
  parameter int NB_OPCODE      = 5,
  parameter int INS_MEM_DEPTH  = 2048,
  parameter int DATA_MEM_DEPTH = 1024,
  localparam int NB_PC    = clogb2(INS_MEM_DEPTH-1),
  localparam int NB_DADDR = clogb2(DATA_MEM_DEPTH-1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
`ifdef BIP_CYCLE_COUNTER_EN
  output logic [31:0]         o_cycles,
`endif
  input  logic                i_run,
  input  logic                i_step,
  output logic                o_halted,
  output logic [NB_PC-1:0]    o_addr_ins,
  input  logic [NB_DATA-1:0]  i_instruction,
  output logic [NB_DADDR-1:0] o_addr_data,
  output logic [NB_DATA-1:0]  o_data,
  input  logic [NB_DATA-1:0]  i_data_mem,
  output logic                o_wr,
  output logic                o_rd,
  output logic [NB_DATA-1:0]  o_acc,
  output logic [NB_PC-1:0]    o_pc
);

  localparam int NB_OPERAND = NB_DATA - NB_OPCODE;

  state_t state_q, state_d;

  logic [NB_PC-1:0]   pc_q, pc_d;
  logic [NB_DATA-1:0] acc_q, acc_d;
  logic [NB_DATA-1:0] ir_q, ir_d;
  logic               step_q, step_d;

  logic [NB_DATA-1:0]    ins;
  logic [NB_OPCODE-1:0]  opc;
  logic [NB_OPERAND-1:0] opd;
  logic [NB_DATA-1:0]    imm, alu_b, alu_y;
  logic                  is_mem, taken;
  logic [NB_PC-1:0]      pc_inc, pc_br;

  // memory word is live only in DECODE; EXEC uses the latched copy
  assign ins = (state_q == S_DECODE) ? i_instruction : ir_q;
  assign opc = ins[NB_DATA-1 -: NB_OPCODE];
  assign opd = ins[NB_OPERAND-1:0];
  assign imm = {{NB_OPCODE{opd[NB_OPERAND-1]}}, opd};

  always_comb begin
    is_mem = 1'b0;
    unique case (int'(opc))
      OP_LD, OP_ADD, OP_SUB,
      OP_AND, OP_OR, OP_XOR: is_mem = 1'b1;
      default:               is_mem = 1'b0;
    endcase
  end

  assign alu_b = is_mem ? i_data_mem : imm;

  bip_alu #(
    .NB_DATA   (NB_DATA),
    .NB_OPCODE (NB_OPCODE)
  ) u_alu (
    .i_acc     (acc_q),
    .i_operand (alu_b),
    .i_opcode  (opc),
    .o_acc     (alu_y)
  );

  always_comb begin
    taken = 1'b0;
    unique case (1'b1)
      int'(opc) == OP_JMP: taken = 1'b1;
      int'(opc) == OP_BEQ: taken = (acc_q == '0);
      int'(opc) == OP_BNE: taken = (acc_q != '0);
      default:             taken = 1'b0;
    endcase
  end

  always_comb begin
    int t;
    pc_inc = pc_q + NB_PC'(1);
    if (int'(pc_q) == INS_MEM_DEPTH-1)
      pc_inc = '0;
    t = int'(pc_inc) + int'($signed(imm));
    t = t % INS_MEM_DEPTH;
    if (t < 0)
      t = t + INS_MEM_DEPTH;
    pc_br = NB_PC'(t);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (i_run || i_step)
          state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE:
        state_d = (int'(opc) == OP_HLT) ?
                  S_HALT : S_EXEC;
      S_EXEC:
        state_d = (step_q || !i_run) ?
                  S_IDLE : S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_halted = (state_q == S_HALT);
    o_rd     = 1'b0;
    o_wr     = 1'b0;
    if (i_rst && state_q == S_DECODE) begin
      o_rd = is_mem;
      o_wr = (int'(opc) == OP_STO);
    end
  end

  always_comb begin
    pc_d   = pc_q;
    acc_d  = acc_q;
    ir_d   = ir_q;
    step_d = step_q;
    unique case (state_q)
      S_IDLE:
        if (i_run || i_step)
          step_d = !i_run;
      S_DECODE: ir_d = i_instruction;
      S_EXEC: begin
        acc_d = alu_y;
        pc_d  = taken ? pc_br : pc_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      pc_q   <= '0;
      acc_q  <= '0;
      ir_q   <= '0;
      step_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      acc_q  <= acc_d;
      ir_q   <= ir_d;
      step_q <= step_d;
    end
  end

`ifdef BIP_CYCLE_COUNTER_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q inside {S_FETCH, S_DECODE, S_EXEC}
        && cyc_q != '1)
      cyc_d = cyc_q + 32'd1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst)
      cyc_q <= '0;
    else
      cyc_q <= cyc_d;
  end

  assign o_cycles = cyc_q;
`endif

  assign o_addr_ins  = pc_q;
  assign o_addr_data = opd[NB_DADDR-1:0];
  assign o_data      = acc_q;
  assign o_acc       = acc_q;
  assign o_pc        = pc_q;

endmodule

// File: tb/tb_bip_core_v2.sv
// tb_bip_core_v2: vector table, directed timing sequences
// and random step-mode programs against an ISA model.
module tb_bip_core_v2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run, step;
  logic        halted, wr, rd;
  logic [10:0] addr_ins, pc;
  logic [9:0]  addr_data;
  logic [15:0] ins_q, dout, rdata_q, acc;
`ifdef BIP_CYCLE_COUNTER_EN
  logic [31:0] cycles;
`endif

  logic [15:0] pmem  [2048];
  logic [15:0] dmem  [1024];
  logic [15:0] dinit [1024];
  logic        dload;

  int errs   = 0;
  int checks = 0;

  bip_core_v2 dut (
    .i_clk         (clk),
    .i_rst         (rst),
`ifdef BIP_CYCLE_COUNTER_EN
    .o_cycles      (cycles),
`endif
    .i_run         (run),
    .i_step        (step),
    .o_halted      (halted),
    .o_addr_ins    (addr_ins),
    .i_instruction (ins_q),
    .o_addr_data   (addr_data),
    .o_data        (dout),
    .i_data_mem    (rdata_q),
    .o_wr          (wr),
    .o_rd          (rd),
    .o_acc         (acc),
    .o_pc          (pc)
  );

  // synchronous program and data memories
  always @(posedge clk) begin
    ins_q   <= pmem[addr_ins];
    rdata_q <= dmem[addr_data];
    if (dload)
      dmem <= dinit;
    else if (wr)
      dmem[addr_data] <= dout;
  end

  typedef struct {
    logic [0:7][15:0] prog;
    logic [15:0]      acc;
    int               pc;
  } vec_t;

  localparam logic [15:0] H = 16'h0000;

  vec_t tv[13];

  int          mpc;
  logic [15:0] macc;
  bit          mhalt;
  logic [15:0] mmem [1024];

  function automatic logic [15:0] enc(int op, int opd);
    logic [4:0]  o;
    logic [10:0] d;
    o = 5'(op);
    d = 11'(opd);
    return {o, d};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) pmem[i] = H;
    for (int i = 0; i < 1024; i++) dinit[i] = 16'h0;
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    run   = 1'b0;
    step  = 1'b0;
    dload = 1'b1;
    tick();
    dload = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic step_once();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic run_to_halt(output bit ok);
    int n;
    n = 0;
    run = 1'b1;
    while (!halted && n < 400) begin
      tick();
      n++;
    end
    run = 1'b0;
    ok = halted;
  endtask

  // ISA-level reference: one instruction per call
  task automatic model_step();
    logic [15:0] w, imm, m;
    logic [3:0]  sh;
    int op, a, nxt, tgt;
    w   = pmem[mpc];
    op  = int'(w[15:11]);
    imm = {{5{w[10]}}, w[10:0]};
    a   = int'(w[9:0]);
    m   = mmem[a];
    sh  = w[3:0];
    nxt = (mpc + 1) % 2048;
    tgt = ((mpc + 1 + int'($signed(imm))) % 2048 + 2048) % 2048;
    case (op)
      0:  mhalt = 1'b1;
      1:  mmem[a] = macc;
      2:  macc = m;
      3:  macc = imm;
      4:  macc = macc + m;
      5:  macc = macc + imm;
      6:  macc = macc - m;
      7:  macc = macc - imm;
      8:  macc = macc & m;
      9:  macc = macc & imm;
      10: macc = macc | m;
      11: macc = macc | imm;
      12: macc = macc ^ m;
      13: macc = macc ^ imm;
      14: macc = macc << sh;
      15: macc = $signed(macc) >>> sh;
      16: if (macc == 16'h0) nxt = tgt;
      17: if (macc != 16'h0) nxt = tgt;
      18: nxt = tgt;
      default: ;
    endcase
    if (!mhalt) mpc = nxt;
  endtask

  initial begin
    bit ok;
    int diffs;

    tv[0]  = '{{enc(3,5), enc(5,'h7FD), enc(1,10),
                H, H, H, H, H}, 16'h0002, 3};
    tv[1]  = '{{enc(3,'h7FF), enc(5,1),
                H, H, H, H, H, H}, 16'h0000, 2};
    tv[2]  = '{{enc(3,'h7FF),
                H, H, H, H, H, H, H}, 16'hFFFF, 1};
    tv[3]  = '{{enc(3,'h400), enc(15,2),
                H, H, H, H, H, H}, 16'hFF00, 2};
    tv[4]  = '{{enc(3,0), enc(16,1), enc(3,7), enc(3,9),
                H, H, H, H}, 16'h0009, 4};
    tv[5]  = '{{enc(3,0), enc(17,1), enc(3,7), enc(3,9),
                H, H, H, H}, 16'h0009, 4};
    tv[6]  = '{{enc(18,'h7FE),
                H, H, H, H, H, H, H}, 16'h0000, 2047};
    tv[7]  = '{{enc(3,'hF0), enc(11,'hF), enc(13,'h7FF),
                enc(9,'h3F0), H, H, H, H}, 16'h0300, 4};
    tv[8]  = '{{enc(3,'h123), enc(1,5), enc(3,0), enc(4,5),
                enc(4,5), enc(14,1), H, H}, 16'h048C, 6};
    tv[9]  = '{{enc(3,'h55), enc(1,3), enc(3,'hF), enc(12,3),
                enc(10,3), enc(8,3), H, H}, 16'h0055, 6};
    tv[10] = '{{enc(3,3), enc(25,0), enc(7,5),
                H, H, H, H, H}, 16'hFFFE, 3};
    tv[11] = '{{enc(3,'h10), enc(1,7), enc(3,1), enc(6,7),
                H, H, H, H}, 16'hFFF1, 4};
    tv[12] = '{{enc(3,'h2A), enc(1,'h7FF), enc(3,0),
                enc(2,'h3FF), H, H, H, H}, 16'h002A, 4};

    // reset state
    clear_mem();
    do_reset();
    chk("rst_pc", pc, 0);
    chk("rst_acc", acc, 0);
    chk("rst_wr", wr, 0);
    chk("rst_rd", rd, 0);
    chk("rst_halt", halted, 0);
    tick();
    chk("idle_pc", pc, 0);

    // run timing
    clear_mem();
    for (int j = 0; j < 8; j++) pmem[j] = tv[0].prog[j];
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      chk($sformatf("t%0d_wr", c), wr, (c == 8));
      chk($sformatf("t%0d_halt", c), halted, (c >= 12));
      if (c == 8) begin
        chk("t_addr", addr_data, 10);
        chk("t_data", dout, 2);
      end
    end
    chk("t_pc", pc, 3);
    chk("t_mem", dmem[10], 16'h0002);
`ifdef BIP_CYCLE_COUNTER_EN
    chk("t_cycles", cycles, 11);
`endif
    run = 1'b0;

    // vector table
    for (int k = 0; k < 13; k++) begin
      clear_mem();
      for (int j = 0; j < 8; j++) pmem[j] = tv[k].prog[j];
      do_reset();
      run_to_halt(ok);
      chk($sformatf("v%0d_halt", k), ok, 1);
      chk($sformatf("v%0d_acc", k), acc, tv[k].acc);
      chk($sformatf("v%0d_pc", k), pc, tv[k].pc);
    end

    // step mode and ignored pulse
    clear_mem();
    pmem[0] = enc(3, 5);
    pmem[1] = enc(5, 1);
    pmem[2] = enc(5, 1);
    do_reset();
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("s_c1", pc, 0);
    tick();
    chk("s_c2", pc, 0);
    tick();
    chk("s_c3", pc, 0);
    tick();
    chk("s_c4_pc", pc, 1);
    chk("s_c4_acc", acc, 5);
    tick();
    tick();
    chk("s_hold", pc, 1);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    chk("s2_pc", pc, 2);
    chk("s2_acc", acc, 6);
    for (int i = 0; i < 4; i++) tick();
    chk("s2_ign_pc", pc, 2);
    chk("s2_ign_acc", acc, 6);

    // i_run dropped mid-instruction
    clear_mem();
    for (int i = 0; i < 10; i++) pmem[i] = enc(5, 1);
    do_reset();
    run = 1'b1;
    tick();
    tick();
    run = 1'b0;
    tick();
    tick();
    chk("drop_pc", pc, 1);
    for (int i = 0; i < 3; i++) tick();
    chk("drop_hold", pc, 1);
    chk("drop_acc", acc, 1);

    // reset during STO decode
    clear_mem();
    pmem[0]   = enc(3, 5);
    pmem[1]   = enc(1, 10);
    dinit[10] = 16'hABCD;
    do_reset();
    step_once();
    chk("rs_acc5", acc, 5);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    chk("rs_wr_pre", wr, 1);
    rst = 1'b0;
    #1;
    chk("rs_wr_rst", wr, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("rs_mem", dmem[10], 16'hABCD);
    chk("rs_pc", pc, 0);
    chk("rs_acc", acc, 0);

    // PC wrap 2047 -> 0
    clear_mem();
    pmem[0]    = enc(5, 1);
    pmem[1]    = enc(18, 'h7FD);
    pmem[2047] = enc(19, 0);
    do_reset();
    step_once();
    chk("w_pc1", pc, 1);
    step_once();
    chk("w_pc2047", pc, 2047);
    step_once();
    chk("w_pc0", pc, 0);
    step_once();
    chk("w_acc", acc, 2);

    // random programs in step mode
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 2048; i++)
        pmem[i] = 16'($urandom);
      for (int i = 0; i < 1024; i++)
        dinit[i] = 16'($urandom);
      do_reset();
      for (int i = 0; i < 1024; i++) mmem[i] = dinit[i];
      mpc   = 0;
      macc  = 16'h0;
      mhalt = 1'b0;
      for (int s = 0; s < 60; s++) begin
        step_once();
        model_step();
        chk($sformatf("r%0d_%0d_pc", p, s), pc, mpc);
        chk($sformatf("r%0d_%0d_acc", p, s), acc, macc);
        chk($sformatf("r%0d_%0d_h", p, s), halted, mhalt);
        if (mhalt) break;
      end
      diffs = 0;
      for (int i = 0; i < 1024; i++)
        if (dmem[i] !== mmem[i]) diffs++;
      chk($sformatf("r%0d_mem", p), diffs, 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
